// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of NUM_REQ requesters onto the
// single register-file write port, plus the per-register pending-write scoreboard.
module rf_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  input  logic                          sb_set,
  input  logic [ADDR_WIDTH-1:0]         sb_set_addr,
  input  logic                          sb_flush,
  input  logic [ADDR_WIDTH-1:0]         sb_q1_addr,
  input  logic [ADDR_WIDTH-1:0]         sb_q2_addr,
  output logic                          sb_q1_busy,
  output logic                          sb_q2_busy,
  output logic [(2**ADDR_WIDTH)-1:0]    busy_vec
);

  localparam int NREG  = 2**ADDR_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      gidx_s;
  logic                  found_s;
  logic                  xfer_s;
  logic [ADDR_WIDTH-1:0] gaddr_s;
  logic [DATA_WIDTH-1:0] gdata_s;
  logic                  rf_wen_r;
  logic [ADDR_WIDTH-1:0] rf_waddr_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;
  logic [NREG-1:0]       busy_r;
  logic [NREG-1:0]       busy_nxt_s;

  // Round-robin search from the pointer upward; looks only at req_valid
  always_comb begin
    int idx;
    gidx_s  = '0;
    found_s = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_r) + k) % NUM_REQ;
      if (!found_s && req_valid[PTR_W'(idx)]) begin
        found_s = 1'b1;
        gidx_s  = PTR_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign xfer_s    = found_s & rst;
  assign req_ready = xfer_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_s) : '0;
  assign gaddr_s   = req_addr[gidx_s*ADDR_WIDTH +: ADDR_WIDTH];
  assign gdata_s   = req_data[gidx_s*DATA_WIDTH +: DATA_WIDTH];

  // Pointer moves just past the winner so it has lowest priority next time
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= (gidx_s == PTR_W'(NUM_REQ-1)) ? '0 : gidx_s + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Registered write port; x0 writes are consumed but never enabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= '0;
      rf_wdata_r <= '0;
    end else if (xfer_s) begin
      rf_wen_r   <= (gaddr_s != '0);
      rf_waddr_r <= gaddr_s;
      rf_wdata_r <= gdata_s;
    end else begin
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  // Scoreboard next state: flush beats everything, set beats clear
  always_comb begin
    busy_nxt_s = busy_r;
    if (sb_flush) begin
      busy_nxt_s = '0;
    end else begin
      if (rf_wen_r) begin
        busy_nxt_s[rf_waddr_r] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (sb_set && (sb_set_addr != '0)) begin
        busy_nxt_s[sb_set_addr] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rf_wen     = rf_wen_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;
  assign busy_vec   = busy_r;
  assign sb_q1_busy = busy_r[sb_q1_addr];
  assign sb_q2_busy = busy_r[sb_q2_addr];

endmodule
